bus_arbiter_rr: RTL and testbench

- Round-robin arbiter sharing one datapath bus between NumberOfRequesters masters.
- Drives the Select input of the team's N-to-1 bus multiplexer and returns a per-requester Grant.
- Requesters hold Request high for the whole transfer; the grant is held until that Request drops.
- One dead (turnaround) cycle is inserted between owners so the mux never switches mid-transfer.

---
 rtl/bus_arbiter_rr.sv | 177 +++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter for a shared datapath bus.
//
// A requester holds its Request bit for the whole transfer and keeps the
// grant until it drops that bit. One dead cycle (TURN) separates owners so
// the downstream mux never switches in the middle of a transfer.
//
// Optional feature macro: ARB_TIMEOUT_EN (grant length limit + TimedOut).
//
// Ports:
//   Clock     in   rising-edge clock
//   Reset_n   in   asynchronous active-low reset
//   Request   in   [N]  bit i high = master i wants or holds the bus
//   Grant     out  [N]  one-hot registered grant, zero when no owner
//   Select    out  [N]  zero-extended owner index, drives the mux select
//   BusValid  out       high while a grant is active
//   Owner     out  [4]  owner index, same value as Select[3:0]
//   TimedOut  out       one-cycle pulse on timeout revocation (0 if disabled)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no owner, arbitrating every cycle
// OWNED | grant held while Request[owner] stays high
// TURN  | one dead cycle after release; arbitrates for the next owner
module bus_arbiter_rr #(
  parameter int NumberOfRequesters = 4,
  parameter int TimeoutCycles      = 64
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic [NumberOfRequesters-1:0] Request,
  output logic [NumberOfRequesters-1:0] Grant,
  output logic [NumberOfRequesters-1:0] Select,
  output logic                          BusValid,
  output logic [3:0]                    Owner,
  output logic                          TimedOut
);

  localparam int IdxW = (NumberOfRequesters > 1) ? $clog2(NumberOfRequesters) : 1;
  localparam logic [IdxW-1:0] LastInit = IdxW'(NumberOfRequesters - 1);

  if (NumberOfRequesters < 2 || NumberOfRequesters > 16) begin : g_bad_n
    $error("bus_arbiter_rr: NumberOfRequesters must be 2..16");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("bus_arbiter_rr: TimeoutCycles must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;

  state_t                        state_q, state_d;
  logic [NumberOfRequesters-1:0] grant_q, grant_d;
  logic [IdxW-1:0]               owner_q, owner_d;
  logic [IdxW-1:0]               last_q, last_d;
  logic                          valid_q, valid_d;
  logic [NumberOfRequesters-1:0] req_eff;
  logic                          found;
  logic [IdxW-1:0]               winner;

`ifdef ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [NumberOfRequesters-1:0] mask_q, mask_d;
  logic                          to_q, to_d;

  // A revoked master stays out of arbitration until it drops Request.
  assign req_eff  = Request & ~mask_q;
  assign TimedOut = to_q;
`else
  assign req_eff  = Request;
  assign TimedOut = 1'b0;
`endif

  // First set bit searching upward from last_q+1, wrapping; the previous
  // owner is therefore checked last.
  always_comb begin
    int cand;
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 1; k <= NumberOfRequesters; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NumberOfRequesters) cand = cand - NumberOfRequesters;
      if (!found && req_eff[cand[IdxW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    mask_d  = mask_q & Request;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE, TURN: begin
        grant_d = '0;
        valid_d = 1'b0;
        state_d = IDLE;
        if (found) begin
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          last_d          = winner;
          valid_d         = 1'b1;
          state_d         = OWNED;
`ifdef ARB_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end
      end
      OWNED: begin
        if (!Request[owner_q]) begin
          grant_d = '0;
          valid_d = 1'b0;
          state_d = TURN;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          grant_d         = '0;
          valid_d         = 1'b0;
          to_d            = 1'b1;
          mask_d[owner_q] = 1'b1;
          state_d         = TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LastInit;
      valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      mask_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      to_q    <= to_d;
`endif
    end
  end

  // Select and Owner are zero-extended views of the owner register, so
  // they hold their value through TURN and IDLE.
  assign Grant    = grant_q;
  assign BusValid = valid_q;
  assign Select   = {{(NumberOfRequesters - IdxW){1'b0}}, owner_q};
  assign Owner    = 4'(owner_q);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed vector table plus hand sequences for the
// multi-cycle corners (no-preemption gap, async reset, timeout).
module tb_bus_arbiter_rr;

  logic       Clock;
  logic       Reset_n;
  logic [3:0] Request;
  logic [3:0] Grant;
  logic [3:0] Select;
  logic       BusValid;
  logic [3:0] Owner;
  logic       TimedOut;

  int n_vec = 0;
  int n_bad = 0;

  bus_arbiter_rr #(
    .NumberOfRequesters(4),
    .TimeoutCycles(8)
  ) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .Request(Request),
    .Grant(Grant),
    .Select(Select),
    .BusValid(BusValid),
    .Owner(Owner),
    .TimedOut(TimedOut)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] sel;
    logic       valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input logic [3:0] g,
                     input logic [3:0] s, input logic v);
    vec_t e;
    e.req = r; e.grant = g; e.sel = s; e.valid = v;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g,
                            input logic [3:0] s, input logic v);
    check({tag, ".grant"}, 32'(Grant), 32'(g));
    check({tag, ".select"}, 32'(Select), 32'(s));
    check({tag, ".owner"}, 32'(Owner), 32'(s));
    check({tag, ".busvalid"}, 32'(BusValid), 32'(v));
    check({tag, ".timedout"}, 32'(TimedOut), 32'(0));
  endtask

  task automatic do_reset;
    Reset_n = 1'b0;
    Request = 4'b0000;
    repeat (3) step();
    Reset_n = 1'b1;
  endtask

  initial begin
    int k;

    // req, grant, select, busvalid (outputs after the clock edge)
    // Round robin from reset, 3-cycle grants, 1 dead cycle: 0,1,2,3,0
    add(4'b1111, 4'b0001, 4'd0, 1'b1);
    add(4'b1111, 4'b0001, 4'd0, 1'b1);
    add(4'b1111, 4'b0001, 4'd0, 1'b1);
    add(4'b1110, 4'b0000, 4'd0, 1'b0);
    add(4'b1111, 4'b0010, 4'd1, 1'b1);
    add(4'b1111, 4'b0010, 4'd1, 1'b1);
    add(4'b1111, 4'b0010, 4'd1, 1'b1);
    add(4'b1101, 4'b0000, 4'd1, 1'b0);
    add(4'b1111, 4'b0100, 4'd2, 1'b1);
    add(4'b1111, 4'b0100, 4'd2, 1'b1);
    add(4'b1111, 4'b0100, 4'd2, 1'b1);
    add(4'b1011, 4'b0000, 4'd2, 1'b0);
    add(4'b1111, 4'b1000, 4'd3, 1'b1);
    add(4'b1111, 4'b1000, 4'd3, 1'b1);
    add(4'b1111, 4'b1000, 4'd3, 1'b1);
    add(4'b0111, 4'b0000, 4'd3, 1'b0);
    add(4'b1111, 4'b0001, 4'd0, 1'b1);
    add(4'b1111, 4'b0001, 4'd0, 1'b1);
    add(4'b1110, 4'b0000, 4'd0, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 1'b0);
    // Single requester: grant, release, TURN, IDLE
    add(4'b0001, 4'b0001, 4'd0, 1'b1);
    add(4'b0001, 4'b0001, 4'd0, 1'b1);
    add(4'b0000, 4'b0000, 4'd0, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 1'b0);
    // Owner 3 releases, 1001 in TURN wraps to 0; then 3 after 0 releases
    add(4'b1000, 4'b1000, 4'd3, 1'b1);
    add(4'b1000, 4'b1000, 4'd3, 1'b1);
    add(4'b0000, 4'b0000, 4'd3, 1'b0);
    add(4'b1001, 4'b0001, 4'd0, 1'b1);
    add(4'b1001, 4'b0001, 4'd0, 1'b1);
    add(4'b1000, 4'b0000, 4'd0, 1'b0);
    add(4'b1000, 4'b1000, 4'd3, 1'b1);
    add(4'b0000, 4'b0000, 4'd3, 1'b0);
    add(4'b0000, 4'b0000, 4'd3, 1'b0);

    // Reset state
    Reset_n = 1'b0;
    Request = 4'b0000;
    repeat (3) step();
    check_outs("reset", 4'b0000, 4'd0, 1'b0);
    Reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      Request = vecs[i].req;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].valid);
    end

    // No preemption: owner 2 keeps the bus while 1 waits; 1 granted 2 cycles after drop
    do_reset();
    Request = 4'b0100;
    step();
    check_outs("own2", 4'b0100, 4'd2, 1'b1);
    Request = 4'b0110;
    repeat (3) begin
      step();
      check_outs("own2_hold", 4'b0100, 4'd2, 1'b1);
    end
    Request = 4'b0010;
    k = 6;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (Grant == 4'b0010) begin
        k = c;
        break;
      end
    end
    check("drop_to_grant_cycles", 32'(k), 32'd2);
    check_outs("own1", 4'b0010, 4'd1, 1'b1);

    // Asynchronous reset mid-grant with owner 2, then 0110 -> 1
    Request = 4'b0000;
    repeat (2) step();
    Request = 4'b0100;
    step();
    check_outs("pre_rst", 4'b0100, 4'd2, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    check_outs("async_rst", 4'b0000, 4'd0, 1'b0);
    Request = 4'b0000;
    step();
    Reset_n = 1'b1;
    Request = 4'b0110;
    step();
    check_outs("post_rst_0110", 4'b0010, 4'd1, 1'b1);

    // Second mid-grant reset with owner 2: Last must return to 3, so 1100 -> 2
    Request = 4'b0000;
    repeat (2) step();
    Request = 4'b0100;
    step();
    check_outs("pre_rst2", 4'b0100, 4'd2, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    check_outs("async_rst2", 4'b0000, 4'd0, 1'b0);
    Request = 4'b0000;
    step();
    Reset_n = 1'b1;
    Request = 4'b1100;
    step();
    check_outs("post_rst_1100", 4'b0100, 4'd2, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // Timeout: 0 held forever, revoked after 8 cycles, masked; 1 granted
    do_reset();
    Request = 4'b0011;
    step();
    check_outs("to_grant0", 4'b0001, 4'd0, 1'b1);
    k = 99;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (TimedOut) begin
        k = c;
        break;
      end
    end
    check("timeout_cycles", 32'(k), 32'd8);
    check("timeout_grant", 32'(Grant), 32'd0);
    check("timeout_busvalid", 32'(BusValid), 32'd0);
    step();
    check_outs("after_to", 4'b0010, 4'd1, 1'b1);
    Request = 4'b0001;
    step();
    check_outs("rel1", 4'b0000, 4'd1, 1'b0);
    repeat (4) begin
      step();
      check_outs("masked0", 4'b0000, 4'd1, 1'b0);
    end
    Request = 4'b0000;
    step();
    Request = 4'b0001;
    step();
    check_outs("unmasked0", 4'b0001, 4'd0, 1'b1);
`else
    // No timeout: grant held indefinitely, TimedOut stays 0
    do_reset();
    Request = 4'b0011;
    repeat (20) begin
      step();
      check_outs("no_to_hold", 4'b0001, 4'd0, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
